vrased_monitor_hub: RTL and testbench

// Parametrised successor to the top-level monitor aggregator. It checks N_REG protected

---
 rtl/vrased_monitor_hub.sv | 274 +++++++++++++++++++++++++++
 tb/tb_vrased_monitor_hub.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vrased_monitor_hub.sv
// vrased_monitor_hub: region/external violation aggregator with a self-releasing PUC reset.
// Define VRASED_MONITOR_LOCKOUT_EN to build the permanent LOCK state.
module vrased_monitor_hub #(
    parameter int                  N_REG          = 4,
    parameter int                  N_EXT          = 2,
    parameter logic [N_REG*16-1:0] REG_BASE       = {N_REG{16'h0000}},
    parameter logic [N_REG*16-1:0] REG_SIZE       = {N_REG{16'h0000}},
    parameter logic [N_REG*16-1:0] CODE_BASE      = {N_REG{16'hA000}},
    parameter logic [N_REG*16-1:0] CODE_SIZE      = {N_REG{16'h4000}},
    parameter logic [N_REG*2-1:0]  REG_MODE       = {N_REG{2'b01}},
    parameter logic [15:0]         RESET_HANDLER  = 16'h0000,
    parameter int                  HOLD_CYCLES    = 4,
    parameter int                  WAIT_MAX       = 16,
    parameter int                  LOCK_THRESHOLD = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [15:0]                        pc,
    input  logic                               data_en,
    input  logic                               data_wr,
    input  logic [15:0]                        data_addr,
    input  logic                               dma_en,
    input  logic [15:0]                        dma_addr,
    input  logic                               irq,
    input  logic [((N_EXT > 0) ? N_EXT : 1)-1:0] ext_viol,
    output logic                               reset,
    output logic [N_REG+N_EXT:0]               viol_cause,
    output logic [15:0]                        viol_pc,
    output logic [7:0]                         viol_count,
    output logic                               locked
);

    localparam int          CW      = N_REG + N_EXT + 1;
    localparam logic [7:0]  HOLD_LD = 8'(HOLD_CYCLES - 1);
    localparam logic [15:0] WAIT_LD = 16'(WAIT_MAX - 1);

    if (N_REG < 1 || N_REG > 8) begin : g_bad_n_reg
        $error("vrased_monitor_hub: N_REG must be 1..8");
    end
    if (N_EXT < 0 || N_EXT > 8) begin : g_bad_n_ext
        $error("vrased_monitor_hub: N_EXT must be 0..8");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("vrased_monitor_hub: HOLD_CYCLES must be 1..255");
    end
    if (WAIT_MAX < 1 || WAIT_MAX > 65536) begin : g_bad_wait
        $error("vrased_monitor_hub: WAIT_MAX must be 1..65536");
    end
    if (LOCK_THRESHOLD < 1) begin : g_bad_lock
        $error("vrased_monitor_hub: LOCK_THRESHOLD must be >= 1");
    end

`ifdef VRASED_MONITOR_LOCKOUT_EN
    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HOLD = 2'd1,
        S_WAIT = 2'd2,
        S_LOCK = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HOLD = 2'd1,
        S_WAIT = 2'd2
    } state_t;
`endif

    // 17-bit end so a window finishing at 16'hFFFF does not wrap; size 0 never matches.
    function automatic logic f_in_win(
        input logic [15:0] a,
        input logic [15:0] b,
        input logic [15:0] s
    );
        logic [16:0] v_end;
        v_end = {1'b0, b} + {1'b0, s};
        return ({1'b0, a} >= {1'b0, b}) && ({1'b0, a} < v_end);
    endfunction

    logic [N_REG-1:0] w_reg_viol;
    logic [N_REG-1:0] w_code_hit;
    logic [N_REG-1:0] w_reg_en;
    logic             w_irq_code;
    logic [CW-1:0]    w_cause;
    logic             w_viol_now;

    for (genvar i = 0; i < N_REG; i++) begin : g_reg
        logic [15:0] w_base;
        logic [15:0] w_size;
        logic [15:0] w_cbase;
        logic [15:0] w_csize;
        logic [1:0]  w_mode;
        logic        w_data_hit;
        logic        w_dma_hit;

        assign w_base  = REG_BASE[i*16 +: 16];
        assign w_size  = REG_SIZE[i*16 +: 16];
        assign w_cbase = CODE_BASE[i*16 +: 16];
        assign w_csize = CODE_SIZE[i*16 +: 16];
        assign w_mode  = REG_MODE[i*2 +: 2];

        assign w_reg_en[i]   = (w_size != 16'h0000);
        assign w_code_hit[i] = f_in_win(pc, w_cbase, w_csize);

        assign w_data_hit = data_en
                          & (data_wr | w_mode[0])
                          & f_in_win(data_addr, w_base, w_size);
        // DMA has no notion of trusted code, so it is flagged whatever the PC.
        assign w_dma_hit  = dma_en
                          & w_mode[1]
                          & f_in_win(dma_addr, w_base, w_size);

        assign w_reg_viol[i] = (w_data_hit & ~w_code_hit[i]) | w_dma_hit;
    end

    assign w_irq_code = irq & |(w_reg_en & w_code_hit);

    if (N_EXT > 0) begin : g_ext
        assign w_cause = {w_irq_code, ext_viol, w_reg_viol};
    end else begin : g_no_ext
        assign w_cause = {w_irq_code, w_reg_viol};
    end

    assign w_viol_now = |w_cause;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_hold_cnt;
    logic [15:0] r_wait_cnt;
    logic        r_reset;
    logic [CW-1:0] r_cause;
    logic [15:0] r_pc;
    logic [7:0]  r_count;
    logic [7:0]  w_cnt_inc;
    logic        w_pc_home;
    logic        w_capture;
    logic        w_hold_load;
    logic        w_hold_dec;
    logic        w_wait_load;
    logic        w_wait_dec;
    logic        w_reset_d;

    assign w_cnt_inc = (r_count == 8'hFF) ? 8'hFF : r_count + 8'd1;
    assign w_pc_home = (pc == RESET_HANDLER);

`ifdef VRASED_MONITOR_LOCKOUT_EN
    localparam logic [8:0] LOCK_TH = 9'(LOCK_THRESHOLD);
    logic w_to_lock;
    logic r_locked;
    assign w_to_lock = ({1'b0, w_cnt_inc} == LOCK_TH);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_RUN: begin
                if (w_viol_now) begin
`ifdef VRASED_MONITOR_LOCKOUT_EN
                    w_next = w_to_lock ? S_LOCK : S_HOLD;
`else
                    w_next = S_HOLD;
`endif
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == 8'd0) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_pc_home) begin
                    w_next = S_RUN;
                end else if (r_wait_cnt == 16'd0) begin
                    w_next = S_HOLD;
                end
            end
`ifdef VRASED_MONITOR_LOCKOUT_EN
            S_LOCK: w_next = S_LOCK;
`endif
            default: w_next = S_RUN;
        endcase
    end

    always_comb begin
        w_capture   = 1'b0;
        w_hold_load = 1'b0;
        w_hold_dec  = 1'b0;
        w_wait_load = 1'b0;
        w_wait_dec  = 1'b0;
        unique case (r_state)
            S_RUN: begin
                w_capture   = w_viol_now;
                w_hold_load = w_viol_now;
            end
            S_HOLD: begin
                if (r_hold_cnt == 8'd0) begin
                    w_wait_load = 1'b1;
                end else begin
                    w_hold_dec = 1'b1;
                end
            end
            S_WAIT: begin
                if (!w_pc_home) begin
                    if (r_wait_cnt == 16'd0) begin
                        w_hold_load = 1'b1;
                    end else begin
                        w_wait_dec = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
`ifdef VRASED_MONITOR_LOCKOUT_EN
        w_reset_d = (w_next == S_HOLD) || (w_next == S_LOCK);
`else
        w_reset_d = (w_next == S_HOLD);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_cnt <= 8'd0;
            r_wait_cnt <= 16'd0;
            r_reset    <= 1'b0;
            r_cause    <= '0;
            r_pc       <= 16'h0000;
            r_count    <= 8'd0;
        end else begin
            r_reset <= w_reset_d;
            if (w_capture) begin
                r_cause <= w_cause;
                r_pc    <= pc;
                r_count <= w_cnt_inc;
            end
            if (w_hold_load) begin
                r_hold_cnt <= HOLD_LD;
            end else if (w_hold_dec) begin
                r_hold_cnt <= r_hold_cnt - 8'd1;
            end
            if (w_wait_load) begin
                r_wait_cnt <= WAIT_LD;
            end else if (w_wait_dec) begin
                r_wait_cnt <= r_wait_cnt - 16'd1;
            end
        end
    end

`ifdef VRASED_MONITOR_LOCKOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_locked <= 1'b0;
        end else begin
            r_locked <= (w_next == S_LOCK);
        end
    end
    assign locked = r_locked;
`else
    assign locked = 1'b0;
`endif

    assign reset      = r_reset;
    assign viol_cause = r_cause;
    assign viol_pc    = r_pc;
    assign viol_count = r_count;

endmodule

// File: tb/tb_vrased_monitor_hub.sv
// tb_vrased_monitor_hub: vector table, corner sequences and randomized run
// checked against a cycle-level behavioural model of the monitor hub.
module tb_vrased_monitor_hub;

    localparam logic [63:0] P_BASE  = {16'h1000, 16'hFF00, 16'h4000, 16'hA000};
    localparam logic [63:0] P_SIZE  = {16'h0000, 16'h0100, 16'h1000, 16'h2000};
    localparam logic [63:0] P_CBASE = {16'h0000, 16'hF000, 16'h8000, 16'hE000};
    localparam logic [63:0] P_CSIZE = {16'hFFFF, 16'h0100, 16'h0100, 16'h1000};
    localparam logic [7:0]  P_MODE  = {2'b11, 2'b01, 2'b11, 2'b00};

    localparam int RB [4] = '{'hA000, 'h4000, 'hFF00, 'h1000};
    localparam int RS [4] = '{'h2000, 'h1000, 'h0100, 'h0000};
    localparam int CB [4] = '{'hE000, 'h8000, 'hF000, 'h0000};
    localparam int CS [4] = '{'h1000, 'h0100, 'h0100, 'hFFFF};
    localparam int RM [4] = '{0, 3, 1, 3};
    localparam int HOLD = 4;
    localparam int WAITN = 16;
    localparam int LOCK_TH = 3;
`ifdef VRASED_MONITOR_LOCKOUT_EN
    localparam bit LOCKOUT = 1'b1;
`else
    localparam bit LOCKOUT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc = 16'h1000;
    logic        data_en = 1'b0;
    logic        data_wr = 1'b0;
    logic [15:0] data_addr = 16'h0000;
    logic        dma_en = 1'b0;
    logic [15:0] dma_addr = 16'h0000;
    logic        irq = 1'b0;
    logic [1:0]  ext_viol = 2'b00;
    logic        reset;
    logic [6:0]  viol_cause;
    logic [15:0] viol_pc;
    logic [7:0]  viol_count;
    logic        locked;

    int total = 0;
    int bad = 0;

    vrased_monitor_hub #(
        .N_REG(4), .N_EXT(2),
        .REG_BASE(P_BASE), .REG_SIZE(P_SIZE),
        .CODE_BASE(P_CBASE), .CODE_SIZE(P_CSIZE),
        .REG_MODE(P_MODE), .RESET_HANDLER(16'h0000),
        .HOLD_CYCLES(HOLD), .WAIT_MAX(WAITN),
        .LOCK_THRESHOLD(LOCK_TH)
    ) dut (
        .clk(clk), .rst(rst), .pc(pc),
        .data_en(data_en), .data_wr(data_wr), .data_addr(data_addr),
        .dma_en(dma_en), .dma_addr(dma_addr), .irq(irq),
        .ext_viol(ext_viol), .reset(reset), .viol_cause(viol_cause),
        .viol_pc(viol_pc), .viol_count(viol_count), .locked(locked)
    );

    always #5 clk = ~clk;

    // Model: 0 run, 1 hold, 2 wait, 3 lock; m_left = cycles remaining in phase.
    int          m_mode;
    int          m_left;
    int          m_cnt;
    logic [6:0]  m_cause;
    logic [15:0] m_pc;

    function automatic bit inwin(int a, int b, int s);
        return (s > 0) && (a >= b) && (a <= b + s - 1);
    endfunction

    function automatic logic [6:0] ref_cause();
        logic [6:0] c;
        bit pcc;
        c = '0;
        for (int r = 0; r < 4; r++) begin
            pcc = inwin(int'(pc), CB[r], CS[r]);
            if (data_en && (data_wr || RM[r][0]) && !pcc
                && inwin(int'(data_addr), RB[r], RS[r]))
                c[r] = 1'b1;
            if (dma_en && RM[r][1] && inwin(int'(dma_addr), RB[r], RS[r]))
                c[r] = 1'b1;
            if (irq && RS[r] > 0 && pcc)
                c[6] = 1'b1;
        end
        c[5:4] = ext_viol;
        return c;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_cnt = 0; m_cause = '0; m_pc = '0;
    endtask

    task automatic model_step();
        logic [6:0] c;
        c = ref_cause();
        case (m_mode)
            0: if (c != 0) begin
                m_cause = c;
                m_pc = pc;
                if (m_cnt < 255) m_cnt++;
                if (LOCKOUT && m_cnt == LOCK_TH) m_mode = 3;
                else begin m_mode = 1; m_left = HOLD; end
            end
            1: begin
                m_left--;
                if (m_left == 0) begin m_mode = 2; m_left = WAITN; end
            end
            2: if (pc == 16'h0000) m_mode = 0;
               else begin
                   m_left--;
                   if (m_left == 0) begin m_mode = 1; m_left = HOLD; end
               end
            default: ;
        endcase
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("m_reset", reset, (m_mode == 1 || m_mode == 3));
        chk("m_locked", locked, (m_mode == 3));
        chk("m_cause", viol_cause, m_cause);
        chk("m_pc", viol_pc, m_pc);
        chk("m_count", viol_count, m_cnt);
    endtask

    task automatic idle();
        data_en = 0; data_wr = 0; data_addr = 0;
        dma_en = 0; dma_addr = 0; irq = 0; ext_viol = 0;
    endtask

    task automatic apply_rst();
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [15:0] pick_addr();
        logic [15:0] tbl [8];
        tbl = '{16'hA000, 16'hBFFF, 16'hC000, 16'h4000,
                16'h4FFF, 16'hFF00, 16'hFFFF, 16'h9FFF};
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        return tbl[$urandom_range(0, 7)];
    endfunction

    typedef struct {
        logic [15:0] pc;
        logic        de;
        logic        dw;
        logic [15:0] da;
        logic        me;
        logic [15:0] ma;
        logic        irq;
        logic [1:0]  ext;
        logic [6:0]  exp;
    } vec_t;

    vec_t tv [$];

    initial begin
        tv.push_back('{16'h1000, 1, 1, 16'hA010, 0, 16'h0000, 0, 2'b00, 7'h01});
        tv.push_back('{16'hE100, 1, 1, 16'hA010, 0, 16'h0000, 0, 2'b00, 7'h00});
        tv.push_back('{16'h1000, 1, 0, 16'hBFFF, 0, 16'h0000, 0, 2'b00, 7'h00});
        tv.push_back('{16'h1000, 1, 0, 16'hC000, 0, 16'h0000, 0, 2'b00, 7'h00});
        tv.push_back('{16'h1000, 1, 1, 16'hC000, 0, 16'h0000, 0, 2'b00, 7'h00});
        tv.push_back('{16'h1000, 1, 1, 16'hBFFF, 0, 16'h0000, 0, 2'b00, 7'h01});
        tv.push_back('{16'h1000, 1, 1, 16'h9FFF, 0, 16'h0000, 0, 2'b00, 7'h00});
        tv.push_back('{16'h1000, 0, 0, 16'h0000, 1, 16'h4800, 0, 2'b10, 7'h22});
        tv.push_back('{16'h8010, 0, 0, 16'h0000, 1, 16'h4800, 0, 2'b00, 7'h02});
        tv.push_back('{16'h8010, 1, 0, 16'h4000, 0, 16'h0000, 0, 2'b00, 7'h00});
        tv.push_back('{16'h1000, 1, 0, 16'h4FFF, 0, 16'h0000, 0, 2'b00, 7'h02});
        tv.push_back('{16'h1000, 1, 0, 16'h5000, 0, 16'h0000, 0, 2'b00, 7'h00});
        tv.push_back('{16'h1000, 1, 0, 16'hFFFF, 0, 16'h0000, 0, 2'b00, 7'h04});
        tv.push_back('{16'hF010, 1, 0, 16'hFFFF, 0, 16'h0000, 0, 2'b00, 7'h00});
        tv.push_back('{16'hF100, 1, 0, 16'hFF00, 0, 16'h0000, 0, 2'b00, 7'h04});
        tv.push_back('{16'h1000, 0, 0, 16'h0000, 1, 16'hFF80, 0, 2'b00, 7'h00});
        tv.push_back('{16'h1000, 0, 0, 16'h0000, 1, 16'hA000, 0, 2'b00, 7'h00});
        tv.push_back('{16'hE100, 0, 0, 16'h0000, 0, 16'h0000, 1, 2'b00, 7'h40});
        tv.push_back('{16'h3000, 0, 0, 16'h0000, 0, 16'h0000, 1, 2'b00, 7'h00});
        tv.push_back('{16'h80FF, 0, 0, 16'h0000, 0, 16'h0000, 1, 2'b00, 7'h40});
        tv.push_back('{16'h8100, 0, 0, 16'h0000, 0, 16'h0000, 1, 2'b00, 7'h00});
        tv.push_back('{16'h1000, 0, 0, 16'h0000, 0, 16'h0000, 0, 2'b01, 7'h10});
        tv.push_back('{16'h1000, 0, 1, 16'hA010, 0, 16'h0000, 0, 2'b00, 7'h00});
        tv.push_back('{16'hE100, 1, 1, 16'h4010, 0, 16'h0000, 1, 2'b11, 7'h72});
        tv.push_back('{16'h1000, 1, 1, 16'hA010, 1, 16'h4000, 0, 2'b00, 7'h03});

        model_reset();
        #12;
        apply_rst();
        chk("rst_reset", reset, 0);
        chk("rst_cause", viol_cause, 0);
        chk("rst_pc", viol_pc, 0);
        chk("rst_count", viol_count, 0);
        chk("rst_locked", locked, 0);

        foreach (tv[i]) begin
            apply_rst();
            pc = tv[i].pc; data_en = tv[i].de; data_wr = tv[i].dw;
            data_addr = tv[i].da; dma_en = tv[i].me; dma_addr = tv[i].ma;
            irq = tv[i].irq; ext_viol = tv[i].ext;
            step();
            chk($sformatf("tv%0d_reset", i), reset, tv[i].exp != 0);
            chk($sformatf("tv%0d_cause", i), viol_cause, tv[i].exp);
            chk($sformatf("tv%0d_count", i), viol_count, (tv[i].exp != 0) ? 1 : 0);
            chk($sformatf("tv%0d_pc", i), viol_pc, (tv[i].exp != 0) ? tv[i].pc : 0);
            idle();
        end

        // Held write: HOLD length, ignored repeats, WAIT timeout, return to RUN.
        apply_rst();
        pc = 16'h1000; data_en = 1; data_wr = 1; data_addr = 16'hA010;
        for (int k = 0; k < 4; k++) begin step(); chk("hold_len", reset, 1); end
        chk("seq_cause", viol_cause, 7'h01);
        chk("seq_pc", viol_pc, 16'h1000);
        chk("seq_count", viol_count, 1);
        for (int k = 0; k < 16; k++) begin step(); chk("wait_low", reset, 0); end
        for (int k = 0; k < 4; k++) begin step(); chk("rehold", reset, 1); end
        chk("hold_no_count", viol_count, 1);
        pc = 16'h0000;
        step(); chk("wait_again", reset, 0);
        step(); chk("run_again", reset, 0);
        step(); chk("run_viol", reset, 1);
        chk("run_count", viol_count, 2);
        chk("run_pc", viol_pc, 16'h0000);
        idle();

        // Async rst in the second HOLD cycle.
        apply_rst();
        pc = 16'h1000; ext_viol = 2'b01;
        step();
        idle();
        step();
        chk("hold2_reset", reset, 1);
        rst = 1'b1;
        #1;
        chk("async_reset", reset, 0);
        chk("async_cause", viol_cause, 0);
        chk("async_pc", viol_pc, 0);
        chk("async_count", viol_count, 0);
        chk("async_locked", locked, 0);
        rst = 1'b0;
        model_reset();

`ifdef VRASED_MONITOR_LOCKOUT_EN
        apply_rst();
        for (int v = 0; v < 3; v++) begin
            pc = 16'h1000; data_en = 1; data_wr = 1; data_addr = 16'hA010;
            step();
            idle();
            pc = 16'h0000;
            for (int k = 0; k < 6; k++) step();
        end
        for (int k = 0; k < 120; k++) begin
            step();
            chk("lock_reset", reset, 1);
            chk("lock_locked", locked, 1);
        end
        chk("lock_count", viol_count, 3);
        apply_rst();
        chk("unlock_reset", reset, 0);
        chk("unlock_locked", locked, 0);
`else
        apply_rst();
        for (int v = 0; v < 258; v++) begin
            pc = 16'h1000; data_en = 1; data_wr = 1; data_addr = 16'hA010;
            step();
            idle();
            pc = 16'h0000;
            for (int k = 0; k < 6; k++) step();
        end
        chk("sat_count", viol_count, 8'hFF);
        chk("sat_locked", locked, 0);
`endif

        apply_rst();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) apply_rst();
            case ($urandom_range(0, 7))
                0: pc = 16'h0000;
                1: pc = 16'hE100;
                2: pc = 16'h8010;
                3: pc = 16'hF010;
                default: pc = 16'($urandom);
            endcase
            data_en = ($urandom_range(0, 3) == 0);
            data_wr = $urandom_range(0, 1) != 0;
            data_addr = pick_addr();
            dma_en = ($urandom_range(0, 5) == 0);
            dma_addr = pick_addr();
            irq = ($urandom_range(0, 9) == 0);
            ext_viol = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
